// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic intersection controller.
//   PHASE_W / Ph*    : FSM state encoding, also exported on the phase output
//   NDirMin/NDirMax  : legal range of the approach count
//   params_ok()      : elaboration-time legality check of the parameter set
package traffic_pkg;

  localparam int unsigned PHASE_W = 3;

  localparam logic [PHASE_W-1:0] PhAllRed = 3'd0;
  localparam logic [PHASE_W-1:0] PhGreen  = 3'd1;
  localparam logic [PHASE_W-1:0] PhYellow = 3'd2;
  localparam logic [PHASE_W-1:0] PhFlash  = 3'd3;

  localparam int unsigned NDirMin = 2;
  localparam int unsigned NDirMax = 8;

  function automatic bit params_ok(int unsigned n_dir, int unsigned cnt_w, int unsigned t_green,
                                   int unsigned t_yellow, int unsigned t_allred,
                                   int unsigned t_walk, int unsigned flash_half);
    longint unsigned lim;
    lim = 64'd1 << cnt_w;
    return (n_dir >= NDirMin) && (n_dir <= NDirMax) &&
           (t_green >= 1) && (t_yellow >= 1) && (t_allred >= 1) && (t_walk >= 1) &&
           (flash_half >= 1) && (t_walk <= t_green) &&
           (64'(t_green) < lim) && (64'(t_yellow) < lim) && (64'(t_allred) < lim) &&
           (64'(t_walk) < lim) && (64'(flash_half) < lim);
  endfunction

endpackage

// File: rtl/traffic_intersection_ctrl_if.sv
// Request/lamp bundle of the traffic intersection controller.
//   ped_req, flash_req           : requests toward the controller
//   red, yellow, green, walk     : per-approach lamp drives
//   cur_dir, phase               : status (approach owning green, FSM state)
// master = request source / lamp observer, slave = controller.
interface traffic_intersection_ctrl_if #(
  parameter int unsigned N_DIR = 2
);
  import traffic_pkg::*;

  localparam int unsigned DIR_W = $clog2(N_DIR);

  logic [N_DIR-1:0]   ped_req;
  logic               flash_req;
  logic [N_DIR-1:0]   red;
  logic [N_DIR-1:0]   yellow;
  logic [N_DIR-1:0]   green;
  logic [N_DIR-1:0]   walk;
  logic [DIR_W-1:0]   cur_dir;
  logic [PHASE_W-1:0] phase;

  modport master (
    output ped_req, flash_req,
    input  red, yellow, green, walk, cur_dir, phase
  );

  modport slave (
    input  ped_req, flash_req,
    output red, yellow, green, walk, cur_dir, phase
  );

endinterface

// File: rtl/phase_timer.sv
// Phase down-counter.
//   clk      : rising-edge clock
//   load     : load load_val this cycle (has priority)
//   load_val : value loaded, normally duration-1
//   cnt      : current count
//   expired  : count reads 0; the owning phase ends in this cycle
// Holds at 0 until reloaded; the owner's reset path forces a load.
module phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt     = cnt_q;
  assign expired = (cnt_q == '0);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Round-robin traffic intersection controller with pedestrian walk and flashing-yellow mode.
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : slave side of traffic_intersection_ctrl_if (requests in, lamps/status out)
// All lamp outputs are registered from the next-state decode, so they line up with phase.
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned N_DIR      = 2,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned T_GREEN    = 10,
  parameter int unsigned T_YELLOW   = 3,
  parameter int unsigned T_ALLRED   = 2,
  parameter int unsigned T_WALK     = 6,
  parameter int unsigned FLASH_HALF = 4
) (
  input logic                         clk,
  input logic                         rst,
  traffic_intersection_ctrl_if.slave  bus
);

  localparam int unsigned DIR_W = $clog2(N_DIR);

  if (!params_ok(N_DIR, CNT_W, T_GREEN, T_YELLOW, T_ALLRED, T_WALK, FLASH_HALF)) begin : gen_param_err
    $error("traffic_intersection_ctrl: illegal parameter set");
  end

  logic [PHASE_W-1:0] state_q, state_d;
  logic [DIR_W-1:0]   dir_q, dir_d;
  logic [N_DIR-1:0]   pend_q, pend_d;
  logic               flash_on_q, flash_on_d;
  logic [N_DIR-1:0]   red_q, red_d, yellow_q, yellow_d, green_q, green_d, walk_q, walk_d;
  logic [N_DIR-1:0]   dir_oh_d;
  logic               enter_green;

  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_val;
  logic [CNT_W-1:0]   tmr_cnt;
  logic               tmr_expired;

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk      (clk),
    .load     (tmr_load),
    .load_val (tmr_val),
    .cnt      (tmr_cnt),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    flash_on_d  = flash_on_q;
    pend_d      = pend_q | bus.ped_req;
    enter_green = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = CNT_W'(T_ALLRED - 1);

    case (state_q)
      PhAllRed: begin
        if (tmr_expired) begin
          tmr_load = 1'b1;
          if (bus.flash_req) begin
            state_d    = PhFlash;
            flash_on_d = 1'b1;
            tmr_val    = CNT_W'(FLASH_HALF - 1);
          end else begin
            state_d     = PhGreen;
            enter_green = 1'b1;
            dir_d       = (dir_q == DIR_W'(N_DIR - 1)) ? '0 : dir_q + 1'b1;
            tmr_val     = CNT_W'(T_GREEN - 1);
          end
        end
      end
      PhGreen: begin
        if (tmr_expired) begin
          state_d  = PhYellow;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(T_YELLOW - 1);
        end
      end
      PhYellow: begin
        if (tmr_expired) begin
          state_d  = PhAllRed;
          tmr_load = 1'b1;
        end
      end
      PhFlash: begin
        if (tmr_expired) begin
          tmr_load = 1'b1;
          if (!bus.flash_req) begin
            state_d = PhAllRed;
          end else begin
            flash_on_d = ~flash_on_q;
            tmr_val    = CNT_W'(FLASH_HALF - 1);
          end
        end
      end
      default: begin
        state_d  = PhAllRed;
        tmr_load = 1'b1;
      end
    endcase

    dir_oh_d = N_DIR'(1) << dir_d;

    // A request in the green-entry cycle is already folded into pend_d, so it is served here.
    if (enter_green) begin
      pend_d = pend_d & ~dir_oh_d;
    end

    // Reset reaches the timer through its load path.
    if (!rst) begin
      tmr_load = 1'b1;
      tmr_val  = CNT_W'(T_ALLRED - 1);
    end
  end

  // Lamp decode of the next state.
  always_comb begin
    red_d    = '1;
    yellow_d = '0;
    green_d  = '0;
    walk_d   = '0;
    case (state_d)
      PhGreen: begin
        red_d   = ~dir_oh_d;
        green_d = dir_oh_d;
      end
      PhYellow: begin
        red_d    = ~dir_oh_d;
        yellow_d = dir_oh_d;
      end
      PhFlash: begin
        red_d    = '0;
        yellow_d = {N_DIR{flash_on_d}};
      end
      default: ;
    endcase

    // Walk is granted at green entry and held while the next count stays in the first T_WALK.
    if (enter_green) begin
      walk_d = (pend_q[dir_d] || bus.ped_req[dir_d]) ? dir_oh_d : '0;
    end else if (state_q == PhGreen && !tmr_expired &&
                 tmr_cnt > CNT_W'(T_GREEN - T_WALK)) begin
      walk_d = walk_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= PhAllRed;
      dir_q      <= DIR_W'(N_DIR - 1);
      pend_q     <= '0;
      flash_on_q <= 1'b0;
      red_q      <= '1;
      yellow_q   <= '0;
      green_q    <= '0;
      walk_q     <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      pend_q     <= pend_d;
      flash_on_q <= flash_on_d;
      red_q      <= red_d;
      yellow_q   <= yellow_d;
      green_q    <= green_d;
      walk_q     <= walk_d;
    end
  end

  assign bus.red     = red_q;
  assign bus.yellow  = yellow_q;
  assign bus.green   = green_q;
  assign bus.walk    = walk_q;
  assign bus.cur_dir = dir_q;
  assign bus.phase   = state_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Bench for traffic_intersection_ctrl (N_DIR=2, default timings): directed scenarios then
// random requests, flash and resets, each cycle compared against a phase/age model.
module tb_traffic_intersection_ctrl;
  import traffic_pkg::*;

  localparam int TG = 10, TY = 3, TA = 2, TW = 6, FH = 4;

  logic clk;
  logic rst;

  traffic_intersection_ctrl_if #(.N_DIR(2)) bus ();

  traffic_intersection_ctrl #(
    .N_DIR      (2),
    .CNT_W      (8),
    .T_GREEN    (TG),
    .T_YELLOW   (TY),
    .T_ALLRED   (TA),
    .T_WALK     (TW),
    .FLASH_HALF (FH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_cyc    = 0;

  // Model: which phase, how many cycles into it, which approach, pending requests.
  logic [2:0] m_ph;
  int         m_age;
  int         m_dir;
  logic [1:0] m_pend;
  bit         m_grant;
  bit         m_yon;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, n_cyc, got, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [1:0] ped, input logic fl);
    int dur;
    if (!r) begin
      m_ph = PhAllRed; m_age = 1; m_dir = 1; m_pend = 2'b00; m_grant = 0; m_yon = 0;
      return;
    end
    dur = (m_ph == PhGreen) ? TG : (m_ph == PhYellow) ? TY : (m_ph == PhFlash) ? FH : TA;
    m_pend = m_pend | ped;
    if (m_age < dur) begin
      m_age++;
    end else begin
      m_age = 1;
      if (m_ph == PhAllRed) begin
        if (fl) begin
          m_ph = PhFlash; m_yon = 1;
        end else begin
          m_ph = PhGreen;
          m_dir = (m_dir + 1) % 2;
          m_grant = m_pend[m_dir];
          m_pend[m_dir] = 1'b0;
        end
      end else if (m_ph == PhGreen) begin
        m_ph = PhYellow;
      end else if (m_ph == PhYellow) begin
        m_ph = PhAllRed;
      end else if (!fl) begin
        m_ph = PhAllRed;
      end else begin
        m_yon = !m_yon;
      end
    end
  endtask

  task automatic compare_all();
    logic [1:0] oh, e_red, e_yel, e_grn, e_walk;
    oh = 2'b01 << m_dir;
    e_red = 2'b11; e_yel = 2'b00; e_grn = 2'b00; e_walk = 2'b00;
    if (m_ph == PhGreen) begin
      e_red = ~oh; e_grn = oh;
      if (m_grant && m_age <= TW) e_walk = oh;
    end else if (m_ph == PhYellow) begin
      e_red = ~oh; e_yel = oh;
    end else if (m_ph == PhFlash) begin
      e_red = 2'b00; e_yel = m_yon ? 2'b11 : 2'b00;
    end
    check("red",     32'(bus.red),     32'(e_red));
    check("yellow",  32'(bus.yellow),  32'(e_yel));
    check("green",   32'(bus.green),   32'(e_grn));
    check("walk",    32'(bus.walk),    32'(e_walk));
    check("cur_dir", 32'(bus.cur_dir), 32'(m_dir));
    check("phase",   32'(bus.phase),   32'(m_ph));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(rst, bus.ped_req, bus.flash_req);
    n_cyc++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_ped(input logic [1:0] p);
    bus.ped_req = p;
    cycle();
    bus.ped_req = 2'b00;
  endtask

  task automatic wait_green(input string tag, input logic [1:0] mask);
    bit seen;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.green == mask) begin
        seen = 1;
        break;
      end
      cycle();
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  int t0, t1;

  initial begin
    rst = 1'b0;
    bus.ped_req = 2'b00;
    bus.flash_req = 1'b0;
    run(2);
    rst = 1'b1;

    // Free-running rotation and its period.
    wait_green("wait_g0_a", 2'b01);
    t0 = n_cyc;
    cycle();
    wait_green("wait_g1_a", 2'b10);
    wait_green("wait_g0_b", 2'b01);
    t1 = n_cyc;
    check("period", 32'(t1 - t0), 32'd30);

    // Pedestrian on approach 1 during green[0].
    run(2);
    pulse_ped(2'b10);
    run(40);

    // Late request on approach 0: served only on the next turn.
    wait_green("wait_g0_c", 2'b01);
    run(3);
    pulse_ped(2'b01);
    run(40);

    // Flash from mid-green, then release.
    wait_green("wait_g0_d", 2'b01);
    run(4);
    bus.flash_req = 1'b1;
    run(35);
    bus.flash_req = 1'b0;
    run(30);

    // Reset in the middle of yellow[1] with a request pending.
    wait_green("wait_g1_b", 2'b10);
    pulse_ped(2'b01);
    run(10);
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    check("rst_red", 32'(bus.red), 32'd3);
    run(25);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      bus.ped_req = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 150) == 0) bus.flash_req = ~bus.flash_req;
      rst = ($urandom_range(0, 700) == 0) ? 1'b0 : 1'b1;
      cycle();
    end
    rst = 1'b1;
    bus.ped_req = 2'b00;
    bus.flash_req = 1'b0;
    run(40);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/traffic_intersection_ctrl.md
TRAFFIC_INTERSECTION_CTRL -- requirements
Module: traffic_intersection_ctrl

Interface
REQ-001 SHALL have parameter N_DIR, default 2, number of approaches served round-robin (legal 2..8).
REQ-002 SHALL have parameter CNT_W, default 8, phase timer width.
REQ-003 SHALL have parameters T_GREEN, T_YELLOW, T_ALLRED, T_WALK, defaults 10, 3, 2, 6, phase durations in clk cycles.
REQ-004 SHALL have parameter FLASH_HALF, default 4, flash half-period in cycles.
REQ-005 SHALL have port clk, input, 1, single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have port ped_req, input, N_DIR, pedestrian request per approach; a 1-cycle pulse is sufficient.
REQ-008 SHALL have port flash_req, input, 1, requests flashing-yellow maintenance mode.
REQ-009 SHALL have ports red, yellow, green, output, N_DIR each, lamp drives per approach.
REQ-010 SHALL have port walk, output, N_DIR, pedestrian walk lamp per approach.
REQ-011 SHALL have port cur_dir, output, $clog2(N_DIR), approach currently owning or last owning green.
REQ-012 SHALL have port phase, output, 3, current FSM state encoding.

Function
REQ-013 SHALL implement states ALLRED, GREEN, YELLOW, FLASH; each timed state lasts exactly its T_* cycles.
REQ-014 SHALL use a down-counter loaded with T-1 on state entry; the state exits in the cycle the counter reads 0.
REQ-015 Transitions SHALL be: ALLRED -> GREEN, ALLRED -> FLASH when flash_req=1 at ALLRED expiry; GREEN -> YELLOW; YELLOW -> ALLRED.
REQ-016 On ALLRED -> GREEN, cur_dir SHALL advance to (cur_dir+1) mod N_DIR, with wrap from N_DIR-1 to 0.
REQ-017 Outputs SHALL be Moore, registered, and one-hot per approach. In GREEN/YELLOW, approach cur_dir shows green or yellow and all other approaches show red. In ALLRED, all approaches show red.
REQ-018 ped_req[d] SHALL set a sticky pend[d] bit, and pend[d] SHALL be cleared on entry to GREEN for d.
REQ-019 If ped_req[d] is high in the same cycle GREEN for d is entered, that request SHALL be serviced and cleared; a request arriving later in that green SHALL stay pending for the next turn.
REQ-020 If pend[d] was set at GREEN entry, walk[d] SHALL be high for the first T_WALK cycles of that green, then low. walk SHALL never be high outside GREEN.
REQ-021 FLASH SHALL drive red, green and walk to all 0 and yellow to all-ones or all-zeros. Yellow starts on and toggles every FLASH_HALF cycles.
REQ-022 FLASH SHALL exit to ALLRED, with cur_dir unchanged, at the first half-period boundary where flash_req=0. pend bits SHALL be held throughout FLASH.
REQ-023 Elaboration SHALL fail if any T_* < 1, if T_WALK > T_GREEN, if any T_* or FLASH_HALF >= 2**CNT_W, or if N_DIR is outside 2..8.

Reset
REQ-024 With rst=0 at a clock edge, the block SHALL enter ALLRED and load the timer with T_ALLRED-1.
REQ-025 The same reset SHALL set cur_dir=N_DIR-1 (so the first green is approach 0) and clear all pend bits.
REQ-026 The same reset SHALL drive red all-ones and yellow, green, walk all-zeros on the next cycle.
REQ-027 Reset asserted mid-phase, including during FLASH, SHALL abort the phase immediately with no yellow transition.

Structure
REQ-028 State encoding, phase width and parameter-check constants SHALL live in shared package traffic_pkg.
REQ-029 The down-counter with load/expire SHALL be a sub-module phase_timer, parametrised by CNT_W.
REQ-030 The top SHALL hold the FSM, the cur_dir counter, the pend latches and the output decode.

Verification (N_DIR=2, defaults)
REQ-031 Release reset, no requests. The bench SHALL see red=11 for 2 cycles, then green[0] for 10, yellow[0] for 3, red=11 for 2, then green[1]; the period SHALL be 30 cycles.
REQ-032 Pulse ped_req[1] during green[0]. The bench SHALL see walk[1] high for exactly the first 6 cycles of green[1], and walk[0] stay 0.
REQ-033 Pulse ped_req[0] 3 cycles into green[0]. The bench SHALL see no walk in that green, and walk[0] for 6 cycles in the next green[0].
REQ-034 Hold flash_req=1 from mid-green[0]. The bench SHALL see yellow[0] then all-red complete, then yellow=11 on 4 / off 4, and red=00.
REQ-035 Drop flash_req during FLASH. The bench SHALL see exit at the next 4-cycle boundary, 2 cycles of all-red, then green[1].
REQ-036 Assert rst=0 for 1 cycle mid-yellow[1]. The bench SHALL see red=11 next cycle, green[0] 2 cycles after release, and pend cleared.
